invader_edge_monitor: RTL and testbench
=======================================

// Module: invader_edge_monitor
// PURPOSE
//  Producer of the chgDir pulse consumed by the invader formation mover. Watches the
//  per-pixel invader drawing request during each VGA frame, latches left/right border
//  and bottom-line contacts, and at the next startOfFrame issues one direction-change
//  pulse per border event. Also flags the formation reaching the player line (game over).
// PARAMETERS
//  LEFT_EDGE       2    pixelX <= LEFT_EDGE with invaderDR counts as left-border contact
//  RIGHT_EDGE      637  pixelX >= RIGHT_EDGE with invaderDR counts as right-border contact
//  BOTTOM_LINE     440  pixelY >= BOTTOM_LINE with invaderDR counts as bottom contact
//  HOLDOFF_FRAMES  45   frames after a chgDir during which no new chgDir fires (1.5 s @30Hz)
// PORTS
//  clk            in   1   system clock
//  resetN         in   1   asynchronous, active-low reset
//  startOfFrame   in   1   one-clk pulse at start of each frame
//  pixelX         in   11  current VGA pixel column
//  pixelY         in   11  current VGA pixel row
//  invaderDR      in   1   any invader drawing at (pixelX,pixelY)
//  chgDir         out  1   one-clk pulse: formation must reverse horizontal direction
//  hitSide        out  2   side of last issued chgDir: 00 none, 01 left, 10 right
//  reachedBottom  out  1   sticky: formation touched BOTTOM_LINE
// BEHAVIOUR
//  Reset (resetN=0, async): chgDir=0, hitSide=00, reachedBottom=0, frame flags cleared,
//   holdoff counter=0, state=ARMED.
//  Frame flags leftHit/rightHit/botHit: set on any clk where invaderDR=1 and its pixel
//   condition holds; sticky within the frame.
//  On startOfFrame clk: flags snapshotted for evaluation, then cleared; a contact on that
//   same clk is recorded into the NEW frame (clear takes priority, then set).
//  States: ARMED, HOLDOFF.
//   ARMED: at snapshot, eligible = (rightHit & hitSide!=10) | (leftHit & hitSide!=01).
//     eligible -> chgDir=1 for exactly the clk after startOfFrame; hitSide updated same
//     clk; counter loaded with HOLDOFF_FRAMES; -> HOLDOFF. Otherwise stay ARMED.
//     Both sides eligible same frame: right wins (hitSide=10).
//   HOLDOFF: counter decrements by 1 on each startOfFrame; contacts ignored for chgDir;
//     at counter reaching 0 -> ARMED (evaluation resumes from the following frame).
//  Same-side repeat rule: contact on side equal to hitSide never fires, in any state
//   (formation still touching the border while stepping down does not re-reverse).
//  hitSide=00 after reset: first contact on either side fires.
//  reachedBottom: set at the startOfFrame snapshot when botHit=1; held until reset;
//   independent of state; does not suppress chgDir.
//  chgDir latency: 1 clk after startOfFrame; width always 1 clk; never two pulses
//   within HOLDOFF_FRAMES frames.
//  Counter width: $clog2(HOLDOFF_FRAMES+1); HOLDOFF_FRAMES=0 means return to ARMED on
//   the next startOfFrame.
//  Mid-operation reset: returns to reset values immediately, pending pulse dropped.
// TESTING
//  T1 reset, frame with invaderDR at pixelX=638 -> next SOF+1clk chgDir=1 (1 clk), hitSide=10.
//  T2 after T1, right contact every frame for 100 frames -> no further chgDir, hitSide stays 10.
//  T3 after T1, left contact at pixelX=1 in frame 10 -> no pulse (holdoff); left contact in
//     frame 46 after T1 -> chgDir pulse, hitSide=01.
//  T4 reset, frame with contacts at pixelX=0 and 639 -> single pulse, hitSide=10.
//  T5 invaderDR at pixelY=440 -> reachedBottom=1 after next SOF; stays 1 over 10 frames;
//     pixelY=439 only -> stays 0.
//  T6 contact on same clk as startOfFrame, then none -> pulse after following SOF, not this one;
//     resetN pulse during HOLDOFF -> all outputs 0, next contact either side fires.

Source files
------------

// File: rtl/invader_edge_monitor_if.sv
// Bundle between the VGA pixel scanner / invader drawer and the edge monitor.
// The master side drives the per-pixel stream; the slave side (the monitor)
// returns the direction-change pulse and the border/bottom status.
interface invader_edge_monitor_if;
    logic        startOfFrame;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        invaderDR;
    logic        chgDir;
    logic [1:0]  hitSide;
    logic        reachedBottom;

    modport master (
        output startOfFrame, pixelX, pixelY, invaderDR,
        input  chgDir, hitSide, reachedBottom
    );

    modport slave (
        input  startOfFrame, pixelX, pixelY, invaderDR,
        output chgDir, hitSide, reachedBottom
    );
endinterface

// File: rtl/invader_edge_monitor.sv
// Invader edge monitor: collects border/bottom contacts over a frame and, at
// the next startOfFrame, issues one chgDir pulse per border event with a
// holdoff window so the formation cannot reverse twice in quick succession.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ARMED   | evaluate last frame's contacts at each startOfFrame
// HOLDOFF | chgDir recently issued; count frames down before re-arming
module invader_edge_monitor #(
    parameter int unsigned LEFT_EDGE      = 2,
    parameter int unsigned RIGHT_EDGE     = 637,
    parameter int unsigned BOTTOM_LINE    = 440,
    parameter int unsigned HOLDOFF_FRAMES = 45
) (
    input  logic                  clk,
    input  logic                  resetN,
    invader_edge_monitor_if.slave bus
);

    // A zero holdoff still needs a one-bit counter to exist.
    localparam int unsigned CNT_W = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;

    localparam logic [10:0]      LEFT_X    = 11'(LEFT_EDGE);
    localparam logic [10:0]      RIGHT_X   = 11'(RIGHT_EDGE);
    localparam logic [10:0]      BOTTOM_Y  = 11'(BOTTOM_LINE);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLDOFF_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [1:0] SIDE_NONE  = 2'b00;
    localparam logic [1:0] SIDE_LEFT  = 2'b01;
    localparam logic [1:0] SIDE_RIGHT = 2'b10;

    typedef enum logic {
        ARMED   = 1'b0,
        HOLDOFF = 1'b1
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] holdoff_cnt_q;
    logic             chg_dir_q;
    logic [1:0]       hit_side_q;
    logic             reached_bottom_q;

    logic left_hit_q,  right_hit_q,  bot_hit_q;
    logic left_hit_d,  right_hit_d,  bot_hit_d;
    logic left_now,    right_now,    bot_now;
    logic elig_left,   elig_right;

    assign left_now  = bus.invaderDR && (bus.pixelX <= LEFT_X);
    assign right_now = bus.invaderDR && (bus.pixelX >= RIGHT_X);
    assign bot_now   = bus.invaderDR && (bus.pixelY >= BOTTOM_Y);

    // A side equal to the last reversal never re-fires: the formation is
    // still touching that border while it steps down.
    assign elig_right = right_hit_q && (hit_side_q != SIDE_RIGHT);
    assign elig_left  = left_hit_q  && (hit_side_q != SIDE_LEFT);

    // Frame flags: cleared at startOfFrame, but a contact on that same clock
    // already belongs to the new frame.
    always_comb begin
        left_hit_d  = left_hit_q  | left_now;
        right_hit_d = right_hit_q | right_now;
        bot_hit_d   = bot_hit_q   | bot_now;
        if (bus.startOfFrame) begin
            left_hit_d  = left_now;
            right_hit_d = right_now;
            bot_hit_d   = bot_now;
        end
    end

    // Register the sticky per-frame contact flags.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            left_hit_q  <= 1'b0;
            right_hit_q <= 1'b0;
            bot_hit_q   <= 1'b0;
        end else begin
            left_hit_q  <= left_hit_d;
            right_hit_q <= right_hit_d;
            bot_hit_q   <= bot_hit_d;
        end
    end

    // Frame-boundary evaluation FSM with registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q          <= ARMED;
            holdoff_cnt_q    <= '0;
            chg_dir_q        <= 1'b0;
            hit_side_q       <= SIDE_NONE;
            reached_bottom_q <= 1'b0;
        end else begin
            chg_dir_q <= 1'b0;
            if (bus.startOfFrame) begin
                if (bot_hit_q) begin
                    reached_bottom_q <= 1'b1;
                end
                case (state_q)
                    ARMED: begin
                        if (elig_right || elig_left) begin
                            chg_dir_q     <= 1'b1;
                            hit_side_q    <= elig_right ? SIDE_RIGHT : SIDE_LEFT;
                            holdoff_cnt_q <= HOLD_LOAD;
                            state_q       <= HOLDOFF;
                        end
                    end
                    HOLDOFF: begin
                        // Re-arm on the frame where the count would hit zero;
                        // contacts of that frame are still ignored.
                        if (holdoff_cnt_q <= CNT_ONE) begin
                            holdoff_cnt_q <= '0;
                            state_q       <= ARMED;
                        end else begin
                            holdoff_cnt_q <= holdoff_cnt_q - CNT_ONE;
                        end
                    end
                    default: state_q <= ARMED;
                endcase
            end
        end
    end

    assign bus.chgDir        = chg_dir_q;
    assign bus.hitSide       = hit_side_q;
    assign bus.reachedBottom = reached_bottom_q;

endmodule

// File: tb/tb_invader_edge_monitor.sv
// Bench for invader_edge_monitor: directed frame scenarios plus random frames,
// checked by a scoreboard fed from a frame-level reference model.
module tb_invader_edge_monitor;

    localparam int HOLDOFF = 45;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    invader_edge_monitor_if bus();

    invader_edge_monitor dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    typedef struct packed {
        logic       chg;
        logic [1:0] side;
        logic       bot;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state: contacts seen this frame, SOF index since reset,
    // index of last reversal, last reversal side, bottom reached.
    logic       acc_l, acc_r, acc_b;
    int         frame_idx;
    int         last_fire;
    bit         fired_once;
    logic [1:0] m_side;
    logic       m_bot;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        acc_l = 1'b0; acc_r = 1'b0; acc_b = 1'b0;
        frame_idx = 0; last_fire = 0; fired_once = 1'b0;
        m_side = 2'b00; m_bot = 1'b0;
    endtask

    // One frame boundary: reversal allowed if never reversed or at least
    // HOLDOFF+1 frame boundaries since the last one; right beats left.
    task automatic model_sof();
        exp_t e;
        bit   may_fire, want_r, want_l;
        may_fire = !fired_once || ((frame_idx - last_fire) > HOLDOFF);
        want_r   = acc_r && (m_side != 2'b10);
        want_l   = acc_l && (m_side != 2'b01);
        e.chg    = 1'b0;
        if (may_fire && (want_r || want_l)) begin
            e.chg      = 1'b1;
            m_side     = want_r ? 2'b10 : 2'b01;
            last_fire  = frame_idx;
            fired_once = 1'b1;
        end
        if (acc_b) m_bot = 1'b1;
        e.side = m_side;
        e.bot  = m_bot;
        exp_q.push_back(e);
        frame_idx++;
    endtask

    task automatic cyc(input logic sof, input logic [10:0] x, input logic [10:0] y, input logic dr);
        logic cl, cr, cb;
        @(negedge clk);
        bus.startOfFrame = sof;
        bus.pixelX       = x;
        bus.pixelY       = y;
        bus.invaderDR    = dr;
        cl = dr && (x <= 11'd2);
        cr = dr && (x >= 11'd637);
        cb = dr && (y >= 11'd440);
        if (sof) begin
            model_sof();
            acc_l = cl; acc_r = cr; acc_b = cb;
        end else begin
            acc_l = acc_l | cl; acc_r = acc_r | cr; acc_b = acc_b | cb;
        end
    endtask

    // Filler pixels away from every border, one chosen pixel, then startOfFrame.
    task automatic frame(input int n, input logic [10:0] cx, input logic [10:0] cy, input logic cdr);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 11'($urandom_range(3, 636)), 11'($urandom_range(0, 439)), 1'($urandom_range(0, 1)));
        cyc(1'b0, cx, cy, cdr);
        cyc(1'b1, 11'd300, 11'd100, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetN = 1'b0;
        bus.startOfFrame = 1'b0;
        bus.invaderDR    = 1'b0;
        bus.pixelX       = 11'd0;
        bus.pixelY       = 11'd0;
        model_reset();
        exp_q.delete();
        #1;
        check("reset_outputs_now", {bus.chgDir, bus.hitSide, bus.reachedBottom}, 0);
        @(negedge clk);
        check("reset_outputs_held", {bus.chgDir, bus.hitSide, bus.reachedBottom}, 0);
        resetN = 1'b1;
    endtask

    // Scoreboard monitor: the clock after each startOfFrame pops one expected
    // response; every other clock chgDir must be low.
    initial begin
        bit   s;
        exp_t e;
        forever begin
            @(posedge clk);
            s = bus.startOfFrame && resetN;
            @(negedge clk);
            if (resetN) begin
                if (s) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL scoreboard_underflow at %0t: actual=response expected=none", $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("sof_response{chg,side,bot}", {bus.chgDir, bus.hitSide, bus.reachedBottom}, e);
                    end
                end else begin
                    check("chgDir_idle", bus.chgDir, 0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        logic [10:0] x, y;
        bus.startOfFrame = 1'b0;
        bus.invaderDR    = 1'b0;
        bus.pixelX       = 11'd0;
        bus.pixelY       = 11'd0;
        model_reset();

        // T1 + T3: right reversal, left contact in holdoff, left reversal at frame 46
        do_reset();
        frame(5, 11'd638, 11'd100, 1'b1);
        for (int f = 1; f <= 46; f++) begin
            if (f == 10 || f == 46) frame(4, 11'd1, 11'd50, 1'b1);
            else                    frame(4, 11'd639, 11'd50, 1'b1);
        end

        // T2: persistent right contact never re-fires
        do_reset();
        frame(5, 11'd638, 11'd100, 1'b1);
        for (int f = 0; f < 100; f++) frame(3, 11'd637, 11'd200, 1'b1);

        // T4: both borders in one frame, right wins
        do_reset();
        cyc(1'b0, 11'd0,   11'd10, 1'b1);
        cyc(1'b0, 11'd639, 11'd10, 1'b1);
        cyc(1'b1, 11'd300, 11'd10, 1'b0);
        frame(3, 11'd300, 11'd10, 1'b0);

        // T5: bottom line boundary, sticky
        do_reset();
        frame(4, 11'd300, 11'd439, 1'b1);
        frame(4, 11'd300, 11'd440, 1'b1);
        for (int f = 0; f < 10; f++) frame(3, 11'd300, 11'd100, 1'b0);

        // T6: contact on the SOF clock belongs to the next frame; reset in holdoff
        do_reset();
        frame(4, 11'd300, 11'd100, 1'b0);
        cyc(1'b1, 11'd638, 11'd100, 1'b1);
        frame(4, 11'd300, 11'd100, 1'b0);
        for (int f = 0; f < 3; f++) frame(3, 11'd2, 11'd100, 1'b1);
        do_reset();
        frame(4, 11'd1, 11'd100, 1'b1);
        frame(3, 11'd300, 11'd100, 1'b0);

        // Random frames with boundary-weighted pixels and occasional resets
        do_reset();
        for (int f = 0; f < 400; f++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            for (int i = $urandom_range(2, 7); i >= 0; i--) begin
                r = $urandom_range(0, 19);
                case (r)
                    0:       x = 11'($urandom_range(0, 2));
                    1:       x = 11'($urandom_range(637, 639));
                    2:       x = 11'd3;
                    3:       x = 11'd636;
                    default: x = 11'($urandom_range(4, 635));
                endcase
                y = ($urandom_range(0, 15) == 0) ? 11'($urandom_range(438, 441))
                                                 : 11'($urandom_range(0, 437));
                cyc(i == 0, x, y, ($urandom_range(0, 3) == 0));
            end
        end

        cyc(1'b0, 11'd300, 11'd100, 1'b0);
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
